ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device transmitter for the PS/2 port on the USB D+/D- pads; the same bus already carries device-to-host keyboard/mouse traffic. It takes one command byte (LED update 0xED, reset 0xFF, etc.) over a valid/ready handshake and performs the full request-to-send sequence. The sequence is: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, device ACK. Both PS/2 lines are driven open-drain through output-enable signals; the SoC top level turns each enable into "drive 0, else Z".

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- INHIBIT_US, 100, duration the PS/2 clock line is held low before the start bit.
- TIMEOUT_US, 15000, maximum gap between consecutive device falling edges before abort.
- clk  in  1  system clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- data_i  in  8  byte to send; captured when valid_i && ready_o.
- valid_i  in  1  request to send data_i.
- ready_o  out  1  high only in IDLE.
- done_o  out  1  one-cycle pulse when the transaction ends, whether success or failure.
- error_o  out  1  valid only with done_o: 1 = NACK or timeout, 0 = ACK received.
- ps2_clk_i  in  1  PS/2 clock pad level (asynchronous).
- ps2_data_i  in  1  PS/2 data pad level (asynchronous).
- ps2_clk_oe_o  out  1  1 = pull clock line low.
- ps2_data_oe_o  out  1  1 = pull data line low.

## Operation
- Input conditioning:
  - ps2_clk_i and ps2_data_i each pass through a 2-flop synchronizer.
  - A third clock flop feeds falling-edge detect: fall = prev & ~cur.
- Derived constants:
  - INHIBIT_CYC = CLK_HZ/1_000_000*INHIBIT_US.
  - TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US.
  - A single down-counter of width $clog2(max+1) serves both.
- Frame register (10 bits) = {1'b1 stop, ~^data parity (odd), data[7:0]}, loaded on accept. Bit counter 0..9.
- IDLE:
  - ready_o=1, both OE=0.
  - On valid_i: latch frame, load INHIBIT_CYC, go to INHIBIT.
- INHIBIT:
  - clk_oe=1, data_oe=0.
  - When the counter reaches 0, go to START.
- START:
  - Assert data_oe=1 and clk_oe=0 (release clock) in the same cycle.
  - Load TIMEOUT_CYC, bitcnt=0, go to SEND.
- SEND:
  - On each fall: data_oe <= ~frame[bitcnt], bitcnt++, reload timeout.
  - The fall that drives bit 9 (stop, data released) moves to ACK.
- ACK:
  - On the next fall: sample synced data. 0 = ACK, 1 = NACK. Store the result and go to RELEASE.
- RELEASE:
  - Wait until synced clk=1 and data=1, then go to DONE.
  - The timeout still applies.
- DONE:
  - done_o=1 for one cycle, error_o = stored flag, return to IDLE.
- Timeout: in SEND, ACK or RELEASE, counter==0 means release both lines, set error, go to DONE.
- valid_i outside IDLE is ignored; no queueing.

## Timing
- Reset values:
  - ready_o=1, done_o=0, error_o=0.
  - ps2_clk_oe_o=0, ps2_data_oe_o=0.
  - State IDLE, counters 0.
- Mid-transfer reset releases both lines immediately, because the reset is asynchronous.
- Accept-to-clk_oe: 1 cycle (registered outputs).
- The clock line is held low for exactly INHIBIT_CYC cycles.
- The start bit (data_oe=1) and the clock release occur in the same cycle.
- Data changes 3 cycles after the pad falling edge (2 sync flops + 1 registered output).
- Odd parity: parity bit = 1 when data has an even number of ones.
- done_o and error_o are registered. error_o holds its value until the next done_o.
- ready_o returns to 1 the cycle after done_o.
- A back-to-back accept is possible in that cycle.

## Test plan
- CLK_HZ=1_000_000, send 0xED; device model clocks at 10 kHz and ACKs.
  - Required: clk_oe low for exactly 100 cycles.
  - Required: sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Required: done_o pulse with error_o=0.
- Send 0x01 and 0x00.
  - Required: parity bit 0 for 0x01, 1 for 0x00.
  - Required: ready_o low during each transfer.
- Device model NACKs (data high at ACK edge).
  - Required: done_o=1, error_o=1, both OE=0 afterwards.
- Device never clocks after the start bit (TIMEOUT_US=50).
  - Required: after 50 cycles both OE=0, done_o=1, error_o=1.
- Reset asserted in the middle of SEND.
  - Required: same cycle both OE=0, ready_o=1 after release.
  - Required: a new 0xFF transfer completes OK.
- valid_i held high across two transfers.
  - Required: the second byte is accepted only in the cycle ready_o=1 after done_o.
  - Required: no extra pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data LSB first, odd parity, stop, device ACK.
// Latency: accept to clock inhibit 1 cycle; data line follows each device clock fall by 3 cycles.
// Backpressure: ready_o only in IDLE; valid_i elsewhere is ignored, nothing is queued.
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       error_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LD = CNT_W'(INHIBIT_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SEND, ACK, RELEASE, DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic [9:0]       frame, frame_n;
    logic             ack_err, ack_err_n;
    logic             clk_oe_n, data_oe_n, done_n, err_n, ready_n;
    logic             abort;

    logic [2:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_s, data_s, fall;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_sync[2] & ~clk_sync[1];

    // Synchronize both pads; the idle bus is high so reset to 1 to avoid a false fall.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    // State, counters, frame and registered outputs.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            cnt           <= '0;
            bitcnt        <= '0;
            frame         <= '0;
            ack_err       <= 1'b0;
            ps2_clk_oe_o  <= 1'b0;
            ps2_data_oe_o <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            ready_o       <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bitcnt        <= bitcnt_n;
            frame         <= frame_n;
            ack_err       <= ack_err_n;
            ps2_clk_oe_o  <= clk_oe_n;
            ps2_data_oe_o <= data_oe_n;
            done_o        <= done_n;
            error_o       <= err_n;
            ready_o       <= ready_n;
        end
    end

    // Next state and next registered outputs; a device silence timeout aborts from any bus phase.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        frame_n   = frame;
        ack_err_n = ack_err;
        clk_oe_n  = ps2_clk_oe_o;
        data_oe_n = ps2_data_oe_o;
        done_n    = 1'b0;
        err_n     = error_o;
        ready_n   = ready_o;
        abort     = 1'b0;

        case (state)
            IDLE: begin
                if (valid_i) begin
                    frame_n   = {1'b1, ~^data_i, data_i};
                    cnt_n     = INHIBIT_LD;
                    state_n   = INHIBIT;
                    ready_n   = 1'b0;
                    clk_oe_n  = 1'b1;
                    data_oe_n = 1'b0;
                end
            end
            INHIBIT: begin
                // Leaving on the count of 1 keeps the clock low for exactly INHIBIT_CYC cycles.
                if (cnt <= CNT_ONE) begin
                    state_n   = START;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            START: begin
                cnt_n    = TIMEOUT_LD;
                bitcnt_n = '0;
                state_n  = SEND;
            end
            SEND: begin
                if (fall) begin
                    data_oe_n = ~frame[bitcnt];
                    bitcnt_n  = bitcnt + 4'd1;
                    cnt_n     = TIMEOUT_LD;
                    if (bitcnt == 4'd9) begin
                        state_n = ACK;
                    end
                end else if (cnt <= CNT_ONE) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    ack_err_n = data_s;
                    cnt_n     = TIMEOUT_LD;
                    state_n   = RELEASE;
                end else if (cnt <= CNT_ONE) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RELEASE: begin
                if (clk_s && data_s) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = ack_err;
                end else if (cnt <= CNT_ONE) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase

        if (abort) begin
            state_n   = DONE;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            done_n    = 1'b1;
            err_n     = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a wired-AND PS/2 device model clocking at 10 kHz against a 1 MHz system clock.
// A second instance with a 50 us timeout covers the silent-device abort.
// All DUT outputs are read on the falling system clock edge.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o, done_o, error_o;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe_o, ps2_data_oe_o;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe_o;
    assign ps2_data_i = dev_data & ~ps2_data_oe_o;

    ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .TIMEOUT_US(15000)) u_dut (
        .clk(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .done_o(done_o), .error_o(error_o),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe_o(ps2_clk_oe_o), .ps2_data_oe_o(ps2_data_oe_o)
    );

    // Silent device: lines are only ever pulled by the host.
    logic [7:0] data2;
    logic       valid2;
    logic       ready2, done2, error2, clk_oe2, data_oe2;
    logic       ps2_clk2, ps2_data2;
    assign ps2_clk2  = ~clk_oe2;
    assign ps2_data2 = ~data_oe2;

    ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .TIMEOUT_US(50)) u_dut_to (
        .clk(clk), .reset_i(reset_i), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .done_o(done2), .error_o(error2),
        .ps2_clk_i(ps2_clk2), .ps2_data_i(ps2_data2),
        .ps2_clk_oe_o(clk_oe2), .ps2_data_oe_o(data_oe2)
    );

    int checks = 0;
    int fails  = 0;

    // Monitors
    int   done_cnt = 0;
    int   acc_cnt  = 0;
    int   inh_run  = 0;
    int   inh_len  = 0;
    int   rel_cnt  = 0;
    int   rel_bad  = 0;
    logic last_err = 1'b0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            last_err <= error_o;
        end
        if (ps2_clk_oe_o) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            inh_len <= inh_run;
            inh_run <= 0;
        end
        prev_clk_oe <= ps2_clk_oe_o;
        if (prev_clk_oe && !ps2_clk_oe_o) begin
            rel_cnt <= rel_cnt + 1;
            if (!ps2_data_oe_o) rel_bad <= rel_bad + 1;
        end
    end

    always @(posedge clk) begin
        if (valid_i && ready_o) acc_cnt <= acc_cnt + 1;
    end

    // Device side: wait for the start bit, clock 10 bits (sampled while clock is low), then ACK/NACK.
    task automatic device_run(input logic nack, output logic [9:0] bits, output logic rdy_seen);
        int t;
        bits     = '0;
        rdy_seen = 1'b0;
        t = 0;
        while (!(ps2_data_i == 1'b0 && ps2_clk_oe_o == 1'b0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 5000) begin
            fails++;
            $display("FAIL start_wait: start condition not seen after %0d cycles, required within 5000", t);
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (50) @(negedge clk);
            if (ready_o) rdy_seen = 1'b1;
            bits[i] = ps2_data_i;
            dev_clk = 1'b1;
            repeat (50) @(negedge clk);
        end
        dev_data = nack;
        @(negedge clk);
        dev_clk = 1'b0;
        repeat (50) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic do_transfer(input string name, input logic [7:0] d, input logic par, input logic nack);
        int         d0, r0, rb0, n;
        logic [9:0] bits, exp;
        logic       rdy_seen;
        d0  = done_cnt;
        r0  = rel_cnt;
        rb0 = rel_bad;
        exp = {1'b1, par, d};
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_idle: got %b, required 1", name, ready_o);
        end
        data_i  = d;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        device_run(nack, bits, rdy_seen);
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bits !== exp) begin
            fails++;
            $display("FAIL %s bits: got %b, required %b", name, bits, exp);
        end
        checks++;
        if (rdy_seen !== 1'b0) begin
            fails++;
            $display("FAIL %s ready_busy: ready_o seen %b during transfer, required 0", name, rdy_seen);
        end
        checks++;
        if (inh_len != 100) begin
            fails++;
            $display("FAIL %s inhibit_len: got %0d cycles, required 100", name, inh_len);
        end
        checks++;
        if (rel_cnt - r0 != 1 || rel_bad - rb0 != 0) begin
            fails++;
            $display("FAIL %s start_with_release: releases %0d bad %0d, required 1 and 0", name, rel_cnt - r0, rel_bad - rb0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - d0);
        end
        checks++;
        if (last_err !== nack) begin
            fails++;
            $display("FAIL %s error: got %b, required %b", name, last_err, nack);
        end
        checks++;
        if (ps2_clk_oe_o !== 1'b0 || ps2_data_oe_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL %s after: clk_oe %b data_oe %b ready %b, required 0 0 1", name, ps2_clk_oe_o, ps2_data_oe_o, ready_o);
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        valid2  = 1'b0;
        data2   = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || error_o !== 1'b0 ||
            ps2_clk_oe_o !== 1'b0 || ps2_data_oe_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: rdy %b done %b err %b clk_oe %b data_oe %b, required 1 0 0 0 0",
                     ready_o, done_o, error_o, ps2_clk_oe_o, ps2_data_oe_o);
        end
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || ps2_clk_oe_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: rdy %b clk_oe %b, required 1 0", ready_o, ps2_clk_oe_o);
        end
    endtask

    task automatic test_nack;
        do_transfer("nack", 8'hF4, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (error_o !== 1'b1) begin
            fails++;
            $display("FAIL error_hold: got %b, required 1", error_o);
        end
    endtask

    task automatic test_timeout;
        int n;
        @(negedge clk);
        data2  = 8'h5A;
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        n = 0;
        while (!data_oe2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL to_start: no start bit after %0d cycles, required within 1000", n);
        end
        n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 50 || n > 52) begin
            fails++;
            $display("FAIL to_latency: done after %0d cycles, required 50..52", n);
        end
        checks++;
        if (error2 !== 1'b1 || clk_oe2 !== 1'b0 || data_oe2 !== 1'b0) begin
            fails++;
            $display("FAIL to_abort: err %b clk_oe %b data_oe %b, required 1 0 0", error2, clk_oe2, data_oe2);
        end
        @(negedge clk);
        checks++;
        if (ready2 !== 1'b1 || done2 !== 1'b0) begin
            fails++;
            $display("FAIL to_idle: rdy %b done %b, required 1 0", ready2, done2);
        end
    endtask

    task automatic test_reset_mid_send;
        int n;
        @(negedge clk);
        data_i  = 8'h55;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        n = 0;
        while (!(ps2_data_oe_o && !ps2_clk_oe_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            dev_clk = 1'b0;
            repeat (50) @(negedge clk);
            dev_clk = 1'b1;
            repeat (50) @(negedge clk);
        end
        checks++;
        if (ps2_data_oe_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_send_drive: data_oe %b before reset, required 1 (bit1 of 0x55)", ps2_data_oe_o);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if (ps2_clk_oe_o !== 1'b0 || ps2_data_oe_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL async_release: clk_oe %b data_oe %b ready %b, required 0 0 1", ps2_clk_oe_o, ps2_data_oe_o, ready_o);
        end
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || error_o !== 1'b0) begin
            fails++;
            $display("FAIL after_reset: ready %b done %b err %b, required 1 0 0", ready_o, done_o, error_o);
        end
        do_transfer("ff_after_reset", 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        int         d0, a0, n;
        logic [9:0] bits;
        logic       rdy_seen;
        d0 = done_cnt;
        a0 = acc_cnt;
        @(negedge clk);
        data_i  = 8'hA5;
        valid_i = 1'b1;
        n = 0;
        while (ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        data_i = 8'h3D;
        device_run(1'b0, bits, rdy_seen);
        checks++;
        if (bits !== 10'b1_1_1010_0101) begin
            fails++;
            $display("FAIL b2b_first_bits: got %b, required %b", bits, 10'b1_1_1010_0101);
        end
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_o !== 1'b1 || ready_o !== 1'b0 || error_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done: done %b ready %b err %b, required 1 0 0", done_o, ready_o, error_o);
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_gap: ready %b done %b, required 1 0", ready_o, done_o);
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || ps2_clk_oe_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_accept: ready %b clk_oe %b, required 0 1", ready_o, ps2_clk_oe_o);
        end
        valid_i = 1'b0;
        device_run(1'b0, bits, rdy_seen);
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (bits !== 10'b1_0_0011_1101) begin
            fails++;
            $display("FAIL b2b_second_bits: got %b, required %b", bits, 10'b1_0_0011_1101);
        end
        checks++;
        if (acc_cnt - a0 != 2 || done_cnt - d0 != 2) begin
            fails++;
            $display("FAIL b2b_counts: accepts %0d dones %0d, required 2 2", acc_cnt - a0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        do_transfer("ed", 8'hED, 1'b1, 1'b0);
        do_transfer("01", 8'h01, 1'b0, 1'b0);
        do_transfer("00", 8'h00, 1'b1, 1'b0);
        test_nack();
        test_timeout();
        test_reset_mid_send();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
